// File: rtl/shiftreg_scanner_pkg.sv
// Shared definitions for the shift-chain button scanner.
//   scan_state_t : scan sequencer states
//   REG_*        : Avalon-MM register addresses
//   scan_period  : clk cycles from one scan_done pulse to the next
package shiftreg_scanner_pkg;

  typedef enum logic [2:0] {
    GAP      = 3'd0,
    LOAD     = 3'd1,
    SETTLE   = 3'd2,
    SHIFT_HI = 3'd3,
    SHIFT_LO = 3'd4,
    DONE     = 3'd5
  } scan_state_t;

  localparam logic [1:0] REG_STATE    = 2'd0;
  localparam logic [1:0] REG_PRESSED  = 2'd1;
  localparam logic [1:0] REG_IRQ_MASK = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  // LOAD + SETTLE, one high/low pair per remaining bit, DONE, then the gap.
  function automatic int unsigned scan_period(input int unsigned num_bits,
                                              input int unsigned clk_div,
                                              input int unsigned scan_gap);
    return clk_div * (2 + 2 * (num_bits - 1)) + 1 + scan_gap;
  endfunction

endpackage

// File: rtl/shiftreg_debounce.sv
// Per-bit scan-count debouncer.
//   clk, reset_n  : clock, async active-low reset
//   update        : one-cycle strobe, a complete scan is in pressed_raw
//   pressed_raw   : this scan's levels, 1 = pressed
//   level         : debounced levels
//   rise          : combinational, high for bits whose level goes 0->1 at
//                   this update edge (lets the press latch set on the same
//                   edge that level changes)
module shiftreg_debounce #(
  parameter int NUM_BITS       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                update,
  input  logic [NUM_BITS-1:0] pressed_raw,
  output logic [NUM_BITS-1:0] level,
  output logic [NUM_BITS-1:0] rise
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  // A disagreeing scan seen while the counter already holds DEBOUNCE_SCANS-1
  // is the DEBOUNCE_SCANS-th in a row, so the level flips on that scan.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

  logic [NUM_BITS-1:0] toggle;

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          lvl;

    assign toggle[i] = update && (pressed_raw[i] != lvl) && (cnt == CNT_LAST);
    assign level[i]  = lvl;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (update) begin
        if (pressed_raw[i] == lvl) begin
          cnt <= '0;
        end else if (toggle[i]) begin
          cnt <= '0;
          lvl <= ~lvl;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign rise = toggle & ~level;

endmodule

// File: rtl/shiftreg_button_scanner.sv
// 74HC165-style button chain scanner with debounce, press latch and
// Avalon-MM register interface.
//   clk, reset_n     : clock, async active-low reset
//   shiftreg_in      : serial data from chain (QH)
//   shiftreg_loadn   : parallel load to chain, active-low
//   shiftreg_clk     : shift clock to chain
//   avs_*            : Avalon-MM slave, 2-bit address, read latency 1
//                      0 STATE (RO), 1 PRESSED (W1C), 2 IRQ_MASK (RW),
//                      3 STATUS (RO: bit0 busy, [15:8] scan count)
//   irq              : level interrupt, |(pressed & irq_mask)
//   buttons          : debounced levels, 1 = pressed
//   scan_done        : one-cycle pulse per completed scan
module shiftreg_button_scanner
  import shiftreg_scanner_pkg::*;
#(
  parameter int                  NUM_BITS        = 16,
  parameter int                  CLK_DIV         = 16,
  parameter int                  SCAN_GAP        = 1024,
  parameter int                  DEBOUNCE_SCANS  = 4,
  parameter logic [NUM_BITS-1:0] ACTIVE_LOW_MASK = '1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                shiftreg_in,
  output logic                shiftreg_loadn,
  output logic                shiftreg_clk,
  input  logic [1:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                irq,
  output logic [NUM_BITS-1:0] buttons,
  output logic                scan_done
);

  // One down-counter times every phase; it must hold the longer of the two.
  localparam int CNT_MAX = (CLK_DIV > SCAN_GAP) ? CLK_DIV : SCAN_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(NUM_BITS + 1);

  localparam logic [CW-1:0] DIV_RELOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_RELOAD = CW'(SCAN_GAP - 1);

  scan_state_t         state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [BW-1:0]       bits_left, bits_n;
  logic [NUM_BITS-1:0] raw, raw_n, raw_shift;
  logic [7:0]          scan_cnt;
  logic [NUM_BITS-1:0] press, irq_mask, rise;
  logic                update;
  logic                wr_pressed, wr_mask;
  logic                unused_wdata;

  // Chain is read MSB first: each sample enters at bit 0 and moves up, so
  // after NUM_BITS samples the first one (QH after load) sits at the MSB.
  assign raw_shift = (raw << 1) | NUM_BITS'(shiftreg_in);

  // ---------------------------------------------------------------------------
  // Scan sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= GAP;
      cnt       <= '0;   // gap already expired: load starts right after reset
      bits_left <= '0;
      raw       <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bits_left <= bits_n;
      raw       <= raw_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bits_n  = bits_left;
    raw_n   = raw;
    case (state)
      GAP: begin
        if (cnt == '0) begin
          state_n = LOAD;
          cnt_n   = DIV_RELOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      LOAD: begin
        if (cnt == '0) begin
          state_n = SETTLE;
          cnt_n   = DIV_RELOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          raw_n  = raw_shift;
          bits_n = BW'(NUM_BITS - 1);
          if (NUM_BITS == 1) begin
            state_n = DONE;
          end else begin
            state_n = SHIFT_HI;
            cnt_n   = DIV_RELOAD;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt == '0) begin
          state_n = SHIFT_LO;
          cnt_n   = DIV_RELOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      SHIFT_LO: begin
        // Sampled at the end of the low phase, just before the next rising
        // shift edge, so QH has had a full half-period to settle.
        if (cnt == '0) begin
          raw_n  = raw_shift;
          bits_n = bits_left - 1'b1;
          if (bits_left == BW'(1)) begin
            state_n = DONE;
          end else begin
            state_n = SHIFT_HI;
            cnt_n   = DIV_RELOAD;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE: begin
        state_n = GAP;
        cnt_n   = GAP_RELOAD;
      end
      default: begin
        state_n = GAP;
        cnt_n   = '0;
      end
    endcase
  end

  // Chain strobes are registered from the next state so they change exactly
  // on state boundaries and never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shiftreg_loadn <= 1'b1;
      shiftreg_clk   <= 1'b0;
      scan_done      <= 1'b0;
      scan_cnt       <= '0;
    end else begin
      shiftreg_loadn <= (state_n != LOAD);
      shiftreg_clk   <= (state_n == SHIFT_HI);
      scan_done      <= update;
      if (update) scan_cnt <= scan_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  assign update = (state == DONE);

  shiftreg_debounce #(
    .NUM_BITS       (NUM_BITS),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .update      (update),
    .pressed_raw (raw ^ ACTIVE_LOW_MASK),
    .level       (buttons),
    .rise        (rise)
  );

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  assign wr_pressed   = avs_write && (avs_address == REG_PRESSED);
  assign wr_mask      = avs_write && (avs_address == REG_IRQ_MASK);
  assign unused_wdata = ^avs_writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press    <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      // A press arriving on the clearing cycle is OR-ed in after the clear
      // so it is never lost.
      if (wr_pressed) press <= (press & ~avs_writedata[NUM_BITS-1:0]) | rise;
      else            press <= press | rise;
      if (wr_mask) irq_mask <= avs_writedata[NUM_BITS-1:0];
      irq <= |(press & irq_mask);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        REG_STATE:    avs_readdata <= 32'(buttons);
        REG_PRESSED:  avs_readdata <= 32'(press);
        REG_IRQ_MASK: avs_readdata <= 32'(irq_mask);
        default:      avs_readdata <= {16'h0, scan_cnt, 7'h0, (state != GAP)};
      endcase
    end
  end

endmodule
